fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
//  IF stage + IF/ID pipeline register feeding decode/control. Holds PC, selects next PC from
//  pcsource (seq/branch/jump/illegal), issues instruction-memory requests with ready handshake,
//  honours stall_en from decode, flushes wrong-path fetch on redirect, halts on illegal opcode.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC value loaded on reset
//  ADDR_W    32             PC / address width
//  INST_W    32             instruction width
//  PC_INC    4              sequential PC increment
// PORTS
//  clk          in   1       clock, rising edge
//  rst          in   1       synchronous, active-high reset
//  stall_en     in   1       decode hazard stall; freeze PC and IF/ID
//  pcsource     in   2       00 pc+4, 01 bpc, 10 jpc, 11 illegal (valid only when if_id_valid)
//  bpc          in   ADDR_W  branch target from decode
//  jpc          in   ADDR_W  jump target from decode
//  imem_req     out  1       fetch request
//  imem_addr    out  ADDR_W  fetch address (= pc)
//  imem_rdata   in   INST_W  instruction returned
//  imem_ready   in   1       rdata valid this cycle for current request
//  if_id_inst   out  INST_W  instruction to decode
//  if_id_pc4    out  ADDR_W  its pc+PC_INC
//  if_id_valid  out  1       IF/ID holds a real instruction (0 = bubble)
//  illegal      out  1       sticky; decode saw pcsource=11 on valid instruction
// BEHAVIOUR
//  - Reset: pc=RESET_PC, state=FETCH, imem_req=0 in reset cycle, if_id_inst=0, if_id_pc4=0,
//    if_id_valid=0, illegal=0, skid empty, kill=0.
//  - FSM FETCH: imem_req=1, imem_addr=pc. ready&~stall: IF/ID<={rdata,pc+PC_INC,1}, pc+=PC_INC.
//    ready&stall: rdata into 1-entry skid, go HOLD. ~ready: stay FETCH (wait states, req held).
//  - HOLD: imem_req=0, IF/ID and pc frozen; on ~stall load IF/ID from skid, pc+=PC_INC, ->FETCH.
//  - HALT: imem_req=0, if_id_valid=0, illegal=1; exit only by rst.
//  - Latency: zero-wait memory gives instruction at pc in IF/ID one cycle after req; 1 inst/cycle.
//  - Redirect (if_id_valid & ~stall_en & pcsource in {01,10}): pc<=bpc/jpc; IF/ID bubbled
//    (valid=0); skid cleared; if current request not yet ready, kill=1 and its response dropped;
//    new request issued for target the cycle after kill clears. Redirect beats sequential increment.
//  - pcsource ignored while stall_en=1 or if_id_valid=0 (operands not final / bubble).
//  - if_id_valid & ~stall_en & pcsource=11 -> HALT next cycle; in-flight response discarded.
//  - stall_en with if_id_valid=0 still freezes (bubble held).
//  - pc arithmetic modulo 2^ADDR_W; wrap from all-ones region to 0 silent.
//  - rst mid-wait: request dropped, late imem_ready after reset ignored until imem_req re-asserted.
// CONFIGURATION
//  FETCH_STATS_EN defined: adds outputs stall_cnt[31:0], flush_cnt[31:0], reset 0; stall_cnt +1 per
//   cycle stall_en=1 & state!=HALT; flush_cnt +1 per redirect; both saturate at all-ones.
//  Undefined: ports and counters absent; core behaviour identical.
// STRUCTURE
//  - Shared package/include: pcsource encodings PC_SEQ=2'b00, PC_BR=2'b01, PC_JMP=2'b10,
//    PC_ILL=2'b11; FSM state encodings FETCH/HOLD/HALT; NOP instruction constant.
//  - One sub-module: fetch_skid_buf (1-entry inst+pc4 buffer, load/clear/valid).
//  - Next-PC mux and IF/ID register in top level.
// TESTING
//  1 rst, ready=1 always, no stall -> imem_addr 0,4,8,...; if_id_pc4 4,8,12 one cycle behind.
//  2 stall_en=1 for 3 cycles while ready=1 at pc=8 -> pc holds 8, IF/ID unchanged,
//    inst@8 from skid appears cycle after stall drops, no fetch lost or duplicated.
//  3 valid branch, pcsource=01, bpc=0x40 -> next imem_addr=0x40, one bubble (valid=0), flush_cnt=1.
//  4 ready delayed 2 cycles, jump pcsource=10 jpc=0x100 during wait -> stale rdata dropped,
//    next captured inst is from 0x100.
//  5 pcsource=11 on valid inst -> illegal=1, imem_req=0, valid=0 until rst; rst restores pc=RESET_PC.
//  6 pcsource=01 with stall_en=1 -> ignored, pc holds; acted on once stall drops.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared encodings for the fetch stage (pcsource select,
// fetch FSM states, bubble instruction).
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    PC_SEQ = 2'b00,
    PC_BR  = 2'b01,
    PC_JMP = 2'b10,
    PC_ILL = 2'b11
  } pcsrc_e;

  typedef enum logic [1:0] {
    FETCH = 2'b00,
    HOLD  = 2'b01,
    HALT  = 2'b10
  } fetch_state_e;

  // addi x0,x0,0 placed in IF/ID when a wrong-path instruction is flushed
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/fetch_stage_skid.sv
// fetch_skid_buf: one-entry buffer holding an instruction and its pc+inc
// that arrived from memory while decode was stalled.
module fetch_skid_buf #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned INST_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic [INST_W-1:0] i_inst,
  input  logic [ADDR_W-1:0] i_pc4,
  output logic              o_valid,
  output logic [INST_W-1:0] o_inst,
  output logic [ADDR_W-1:0] o_pc4
);

  logic              r_valid;
  logic [INST_W-1:0] r_inst;
  logic [ADDR_W-1:0] r_pc4;

  // Capture on load, drop on clear (clear wins), synchronous reset to empty
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_inst  <= '0;
      r_pc4   <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_inst  <= i_inst;
      r_pc4   <= i_pc4;
    end
  end

  assign o_valid = r_valid;
  assign o_inst  = r_inst;
  assign o_pc4   = r_pc4;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, next-PC mux, instruction-memory handshake and
// IF/ID pipeline register. Define FETCH_STATS_EN to add the stall_cnt and
// flush_cnt statistics outputs.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       INST_W   = 32,
  parameter int unsigned       PC_INC   = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_en,
  input  logic [1:0]        pcsource,
  input  logic [ADDR_W-1:0] bpc,
  input  logic [ADDR_W-1:0] jpc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              imem_ready,
  output logic [INST_W-1:0] if_id_inst,
  output logic [ADDR_W-1:0] if_id_pc4,
  output logic              if_id_valid,
  output logic              illegal
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  fetch_state_e      r_state;
  logic              r_req;
  logic              r_kill;
  logic              r_valid;
  logic              r_illegal;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_pc4;
  logic [INST_W-1:0] r_inst;

  logic              w_act;
  logic              w_redirect;
  logic              w_ill_hit;
  logic              w_fire;
  logic              w_skid_load;
  logic              w_skid_clear;
  logic              w_skid_valid;
  logic [ADDR_W-1:0] w_pc_seq;
  logic [ADDR_W-1:0] w_target;
  logic [ADDR_W-1:0] w_skid_pc4;
  logic [INST_W-1:0] w_skid_inst;

  // Decode's pcsource is only trusted for a real, unstalled instruction
  always_comb begin
    w_act        = r_valid && !stall_en && (r_state != HALT);
    w_redirect   = w_act && ((pcsource == PC_BR) || (pcsource == PC_JMP));
    w_ill_hit    = w_act && (pcsource == PC_ILL);
    w_fire       = (r_state == FETCH) && r_req && imem_ready;
    w_pc_seq     = r_pc + ADDR_W'(PC_INC);
    w_target     = (pcsource == PC_BR) ? bpc : jpc;
    w_skid_load  = w_fire && stall_en;
    w_skid_clear = (r_state == HOLD) && !stall_en;
  end

  fetch_skid_buf #(
    .ADDR_W (ADDR_W),
    .INST_W (INST_W)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_skid_load),
    .i_clear (w_skid_clear),
    .i_inst  (imem_rdata),
    .i_pc4   (w_pc_seq),
    .o_valid (w_skid_valid),
    .o_inst  (w_skid_inst),
    .o_pc4   (w_skid_pc4)
  );

  // Fetch FSM with PC and IF/ID register; imem_req is registered from next state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= FETCH;
      r_req     <= 1'b0;
      r_kill    <= 1'b0;
      r_pc      <= RESET_PC;
      r_pc4     <= '0;
      r_inst    <= '0;
      r_valid   <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        FETCH: begin
          if (w_ill_hit) begin
            r_state   <= HALT;
            r_req     <= 1'b0;
            r_kill    <= 1'b0;
            r_valid   <= 1'b0;
            r_illegal <= 1'b1;
          end else if (w_redirect) begin
            // An unanswered request cannot be withdrawn: mark it killed and
            // wait for its response before fetching the target.
            r_pc    <= w_target;
            r_valid <= 1'b0;
            r_inst  <= INST_W'(NOP_INST);
            if (r_req && !imem_ready) begin
              r_kill <= 1'b1;
              r_req  <= 1'b0;
            end else begin
              r_req <= 1'b1;
            end
          end else if (r_kill) begin
            if (imem_ready) begin
              r_kill <= 1'b0;
              r_req  <= 1'b1;
            end
          end else if (w_fire) begin
            if (stall_en) begin
              r_state <= HOLD;
              r_req   <= 1'b0;
            end else begin
              r_inst  <= imem_rdata;
              r_pc4   <= w_pc_seq;
              r_valid <= 1'b1;
              r_pc    <= w_pc_seq;
            end
          end else begin
            // Waiting on memory: decode consumed IF/ID unless stalled
            r_req <= 1'b1;
            if (!stall_en) r_valid <= 1'b0;
          end
        end
        HOLD: begin
          if (!stall_en) begin
            r_state <= FETCH;
            r_req   <= 1'b1;
            if (w_ill_hit) begin
              r_state   <= HALT;
              r_req     <= 1'b0;
              r_valid   <= 1'b0;
              r_illegal <= 1'b1;
            end else if (w_redirect) begin
              r_pc    <= w_target;
              r_valid <= 1'b0;
              r_inst  <= INST_W'(NOP_INST);
            end else begin
              r_inst  <= w_skid_inst;
              r_pc4   <= w_skid_pc4;
              r_valid <= w_skid_valid;
              r_pc    <= w_pc_seq;
            end
          end
        end
        HALT: begin
          r_req     <= 1'b0;
          r_valid   <= 1'b0;
          r_illegal <= 1'b1;
        end
        default: begin
          r_state <= FETCH;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = r_req;
  assign imem_addr   = r_pc;
  assign if_id_inst  = r_inst;
  assign if_id_pc4   = r_pc4;
  assign if_id_valid = r_valid;
  assign illegal     = r_illegal;

`ifdef FETCH_STATS_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  // Saturating stall and redirect counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (stall_en && (r_state != HALT) && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_redirect && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`endif

endmodule
